// File: rtl/interface_botoes.sv
// Purpose : conditions the four raw player buttons into one registered one-hot play
//           plus a single-cycle strobe per physical press (sync, debounce, multi-press
//           reject, release re-arm).
// Latency : a clean press settling before edge k strobes after edge k+2+N (N+3 edges).
//           There is no backpressure: the strobes are fire-and-forget.
// Ports   : clock/reset (async, active-high); botoes[3:0] raw buttons; habilita gate;
//           jogada[3:0] last valid play; tem_jogada valid-play strobe;
//           multipla multi-button strobe; db_estado[2:0] FSM state.
module interface_botoes #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes,
  input  logic       habilita,
  output logic [3:0] jogada,
  output logic       tem_jogada,
  output logic       multipla,
  output logic [2:0] db_estado
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    FILTRANDO      = 3'd1,
    VALIDA         = 3'd2,
    INVALIDA       = 3'd3,
    AGUARDA_SOLTAR = 3'd4
  } estado_t;

  logic [3:0]    meta_q;
  logic [3:0]    sinc_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          muda;
  logic          estavel;
  logic          um_botao;
  logic          varios;
  estado_t       estado_q, estado_d;
  logic [3:0]    jogada_q, jogada_d;
  logic          tem_q, tem_d;
  logic          mult_q, mult_d;

  // Two-flop synchroniser; everything downstream sees sinc_q only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 4'd0;
      sinc_q <= 4'd0;
    end else begin
      meta_q <= botoes;
      sinc_q <= meta_q;
    end
  end

  // sinc_q is the sample latched last cycle; meta_q is the value sinc takes on this
  // edge. Comparing them clears the counter on the very edge sinc changes, so the
  // counter reads N once sinc has been unchanged for N+1 cycles.
  assign muda    = (meta_q != sinc_q);
  assign estavel = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (muda) begin
      cnt_d = '0;
    end else if (!estavel) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // x & (x-1) clears the lowest set bit: zero afterwards means at most one bit was set.
  assign um_botao = (sinc_q != 4'd0) && ((sinc_q & (sinc_q - 4'd1)) == 4'd0);
  assign varios   = (sinc_q != 4'd0) && !um_botao;

  // FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // FSM: next state
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      OCIOSO: begin
        // A press seen while disabled is parked until it is released, so raising
        // habilita over a held button never turns it into a play.
        if (sinc_q != 4'd0) begin
          estado_d = habilita ? FILTRANDO : AGUARDA_SOLTAR;
        end
      end
      FILTRANDO: begin
        if (sinc_q == 4'd0) begin
          estado_d = OCIOSO;
        end else if (!habilita) begin
          estado_d = AGUARDA_SOLTAR;
        end else if (estavel && um_botao) begin
          estado_d = VALIDA;
        end else if (estavel && varios) begin
          estado_d = INVALIDA;
        end
      end
      VALIDA:   estado_d = AGUARDA_SOLTAR;
      INVALIDA: estado_d = AGUARDA_SOLTAR;
      AGUARDA_SOLTAR: begin
        if ((sinc_q == 4'd0) && estavel) begin
          estado_d = OCIOSO;
        end
      end
      default:  estado_d = OCIOSO;
    endcase
  end

  // FSM: outputs, computed from the next state so they are registered yet aligned
  // with the cycle spent in VALIDA / INVALIDA.
  always_comb begin
    jogada_d = jogada_q;
    tem_d    = 1'b0;
    mult_d   = 1'b0;
    if (estado_d == VALIDA) begin
      jogada_d = sinc_q;
      tem_d    = 1'b1;
    end
    if (estado_d == INVALIDA) begin
      mult_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      jogada_q <= 4'd0;
      tem_q    <= 1'b0;
      mult_q   <= 1'b0;
    end else begin
      jogada_q <= jogada_d;
      tem_q    <= tem_d;
      mult_q   <= mult_d;
    end
  end

  assign jogada     = jogada_q;
  assign tem_jogada = tem_q;
  assign multipla   = mult_q;
  assign db_estado  = estado_q;

endmodule
